user_io_event_queue: RTL and testbench

- Consumes the polled, level-valued button and link-power outputs of the TCA9555 user-I/O poller.
- Resynchronises, debounces and edge-detects each input, then turns every accepted change into a timestamped 16-bit event word.
- Event words are buffered in a small FIFO and drained over a valid/ready stream toward the host status-packet builder.

---
 rtl/user_io_event_queue.sv | 152 +++++++++++++++
 tb/tb_user_io_event_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/user_io_event_queue.sv
// Resynchronises, debounces and edge-detects user inputs, then queues timestamped event words in a FWFT FIFO.
// Optional link-power events are enabled by defining LINK_POW_EVENTS_EN.
module user_io_event_queue #(
  parameter int CLK_RATE_HZ = 16_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [5:0]  i_button,
  input  logic [3:0]  i_link_pow,
  output logic [15:0] o_evt_data,
  output logic        o_evt_valid,
  input  logic        i_evt_ready,
  output logic [5:0]  o_button_state,
  output logic        o_overflow,
  input  logic        i_clear_overflow
);
  localparam int MS_CYCLES = CLK_RATE_HZ / 1000;
  localparam int DB_CYCLES = MS_CYCLES * DEBOUNCE_MS;
  localparam int DBW = $clog2(DB_CYCLES);
  localparam int MSW = $clog2(MS_CYCLES + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

`ifdef LINK_POW_EVENTS_EN
  localparam int NSRC = 10;
  logic [NSRC-1:0] raw;
  assign raw = {i_link_pow, i_button};
`else
  localparam int NSRC = 6;
  logic [NSRC-1:0] raw;
  logic            unused_link;
  assign raw = i_button;
  assign unused_link = ^i_link_pow;
`endif

  logic [NSRC-1:0] sync1_reg, sync2_reg, stable_reg, stable_next, stable_d_reg;
  logic [NSRC-1:0] pending_reg, pending_next;
  logic [MSW-1:0]  ms_cnt_reg;
  logic [9:0]      ts_reg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      stable_reg   <= '0;
      stable_d_reg <= '0;
      pending_reg  <= '0;
      ms_cnt_reg   <= '0;
      ts_reg       <= '0;
    end else begin
      sync1_reg    <= raw;
      sync2_reg    <= sync1_reg;
      stable_reg   <= stable_next;
      stable_d_reg <= stable_reg;
      pending_reg  <= pending_next;
      if (ms_cnt_reg == MSW'(MS_CYCLES - 1)) begin
        ms_cnt_reg <= '0;
        ts_reg     <= ts_reg + 10'd1;
      end else begin
        ms_cnt_reg <= ms_cnt_reg + 1'b1;
      end
    end
  end

  // Stable level only moves after DB_CYCLES consecutive cycles of disagreement.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_db
      logic [DBW-1:0] cnt_reg;
      logic           accept;
      assign accept = (sync2_reg[gi] != stable_reg[gi]) && (cnt_reg == DBW'(DB_CYCLES - 1));
      assign stable_next[gi] = accept ? sync2_reg[gi] : stable_reg[gi];
      always_ff @(posedge i_clk) begin
        if (i_reset || sync2_reg[gi] == stable_reg[gi] || accept)
          cnt_reg <= '0;
        else
          cnt_reg <= cnt_reg + 1'b1;
      end
    end
  endgenerate

  logic            grant_valid, grant_lvl;
  logic [3:0]      grant_idx;
  logic [NSRC-1:0] grant_mask;
  logic [15:0]     push_word;

  always_comb begin
    grant_valid = 1'b0;
    grant_lvl   = 1'b0;
    grant_idx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        grant_valid = 1'b1;
        grant_lvl   = stable_reg[i];
        grant_idx   = 4'(i);
      end
    end
    grant_mask   = grant_valid ? (NSRC'(1) << grant_idx) : '0;
    pending_next = (pending_reg & ~grant_mask) | (stable_reg ^ stable_d_reg);
    if (grant_idx >= 4'd6)
      push_word = {1'b1, grant_lvl, grant_idx - 4'd6, ts_reg};
    else
      push_word = {1'b0, grant_lvl, grant_idx, ts_reg};
  end

  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [15:0]   data_reg, data_next;
  logic          ovf_reg, pop, push, drop;

  // The head word is kept in a register so it can hold its value once the FIFO drains.
  always_comb begin
    pop         = (count_reg != '0) && i_evt_ready;
    push        = grant_valid && ((count_reg < CW'(FIFO_DEPTH)) || pop);
    drop        = grant_valid && !push;
    rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    count_next  = count_reg + CW'(push) - CW'(pop);
    data_next   = data_reg;
    if (count_next != '0)
      data_next = (push && wr_ptr_reg == rd_ptr_next) ? push_word : mem[rd_ptr_next];
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      data_reg   <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      count_reg <= count_next;
      data_reg  <= data_next;
      if (drop)
        ovf_reg <= 1'b1;
      else if (i_clear_overflow)
        ovf_reg <= 1'b0;
    end
  end

  assign o_evt_valid    = (count_reg != '0);
  assign o_evt_data     = data_reg;
  assign o_button_state = stable_reg[5:0];
  assign o_overflow     = ovf_reg;
endmodule

// File: tb/tb_user_io_event_queue.sv
// Randomised and directed bench for user_io_event_queue against a queue-level behavioural model.
module tb_user_io_event_queue;
  localparam int MS = 10;
  localparam int DB = 10;
  localparam int DEPTH = 8;
`ifdef LINK_POW_EVENTS_EN
  localparam int NSRC = 10;
`else
  localparam int NSRC = 6;
`endif

  logic        clk = 1'b0;
  logic        reset, ready, clr;
  logic [5:0]  button;
  logic [3:0]  link_pow;
  logic [15:0] evt_data;
  logic        evt_valid, overflow;
  logic [5:0]  button_state;

  always #5 clk = ~clk;

  user_io_event_queue #(.CLK_RATE_HZ(10_000), .DEBOUNCE_MS(1), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(reset), .i_button(button), .i_link_pow(link_pow),
    .o_evt_data(evt_data), .o_evt_valid(evt_valid), .i_evt_ready(ready),
    .o_button_state(button_state), .o_overflow(overflow), .i_clear_overflow(clr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: raw levels delayed two cycles, run-length debounce, queue of words.
  logic [NSRC-1:0] m_in, m_s1, m_s2, m_stable, m_chg, m_newchg, m_pend;
  int              m_run [NSRC];
  int              m_k, m_g;
  logic [15:0]     m_q [$];
  logic [15:0]     m_data, m_w;
  logic            m_ovf, m_drop;
  bit              m_live = 0;

`ifdef LINK_POW_EVENTS_EN
  assign m_in = {link_pow, button};
`else
  assign m_in = button;
`endif

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_chg = '0; m_pend = '0;
      for (int i = 0; i < NSRC; i++) m_run[i] = 0;
      m_k = 0; m_q.delete(); m_data = '0; m_ovf = 1'b0; m_live = 1;
    end else begin
      if (m_q.size() != 0 && ready) void'(m_q.pop_front());
      m_g = -1;
      for (int i = NSRC - 1; i >= 0; i--) if (m_pend[i]) m_g = i;
      m_drop = 1'b0;
      if (m_g >= 0) begin
        m_w = {(m_g >= 6), m_stable[m_g], 4'(m_g >= 6 ? m_g - 6 : m_g), 10'((m_k / MS) % 1024)};
        if (m_q.size() < DEPTH) m_q.push_back(m_w);
        else m_drop = 1'b1;
        m_pend[m_g] = 1'b0;
      end
      if (m_drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_pend = m_pend | m_chg;
      m_newchg = '0;
      for (int i = 0; i < NSRC; i++) begin
        if (m_s2[i] == m_stable[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_stable[i] = m_s2[i]; m_run[i] = 0; m_newchg[i] = 1'b1;
          end
        end
      end
      m_chg = m_newchg;
      m_s2 = m_s1;
      m_s1 = m_in;
      m_k++;
      if (m_q.size() != 0) m_data = m_q[0];
    end
  end

  logic [15:0] got [$];
  int          vcnt;

  always @(negedge clk) begin
    if (m_live) begin
      chk("valid", evt_valid, m_q.size() != 0);
      chk("data", evt_data, m_data);
      chk("button_state", button_state, m_stable[5:0]);
      chk("overflow", overflow, m_ovf);
      if (evt_valid && ready) got.push_back(evt_data);
      if (evt_valid) vcnt++;
    end
  end

  function automatic logic [15:0] word_at(input int i);
    return (got.size() > i) ? got[i] : 16'hxxxx;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [15:0] w0, w1;
  logic [15:0] ovf_exp [8] = '{16'h4000, 16'h0400, 16'h0800, 16'h4C00,
                               16'h1000, 16'h5400, 16'h0000, 16'h4400};
  int idx;

  initial begin
    reset = 1'b1; button = '0; link_pow = '0; ready = 1'b0; clr = 1'b0;
    step(3);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_data", evt_data, 16'h0000);
    chk("rst_state", button_state, 6'b0);
    chk("rst_ovf", overflow, 1'b0);
    reset = 1'b0;

    // single press
    got.delete(); vcnt = 0; ready = 1'b1; button[2] = 1'b1;
    step(30);
    chk("press_count", got.size(), 1);
    chk("press_word_hi", word_at(0) & 16'hFC00, 16'h4800);
    chk("press_state", button_state, 6'b000100);
    chk("press_valid_cycles", vcnt, 1);

    // glitch rejection
    got.delete(); button[0] = 1'b1;
    step(5);
    button[0] = 1'b0;
    step(30);
    chk("glitch_count", got.size(), 0);
    chk("glitch_state", button_state, 6'b000100);

    // simultaneous edges
    got.delete(); button[1] = 1'b1; button[4] = 1'b1;
    step(30);
    chk("simul_count", got.size(), 2);
    w0 = word_at(0); w1 = word_at(1);
    chk("simul_w0_hi", w0 & 16'hFC00, 16'h4400);
    chk("simul_w1_hi", w1 & 16'hFC00, 16'h5000);
    chk("simul_ts", ((w1[9:0] - w0[9:0]) <= 10'd1), 1'b1);

    // overflow: 9 accepted edges with the consumer stalled
    ready = 1'b0; got.delete();
    button = ~button;
    step(30);
    button = button ^ 6'b000111;
    step(30);
    chk("ovf_valid", evt_valid, 1'b1);
    chk("ovf_set", overflow, 1'b1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);
    ready = 1'b1;
    step(20);
    chk("ovf_drain_count", got.size(), 8);
    for (int i = 0; i < 8; i++) chk("ovf_drain_word", word_at(i) & 16'hFC00, ovf_exp[i]);

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      ready = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, 9);
        if (idx < 6) button[idx] = ~button[idx];
        else link_pow[idx-6] = ~link_pow[idx-6];
      end
      step(1);
    end
    ready = 1'b1; clr = 1'b0; link_pow = '0;
    step(60);

    // link-power event
    got.delete(); link_pow[3] = 1'b1;
    step(30);
`ifdef LINK_POW_EVENTS_EN
    chk("link_count", got.size(), 1);
    chk("link_word_hi", word_at(0) & 16'hFC00, 16'hCC00);
`else
    chk("link_count", got.size(), 0);
`endif

    // reset with queued entries
    ready = 1'b0;
    button = button ^ 6'b000111;
    step(30);
    chk("preq_valid", evt_valid, 1'b1);
    reset = 1'b1;
    step(1);
    chk("midrst_valid", evt_valid, 1'b0);
    chk("midrst_data", evt_data, 16'h0000);

    // timestamp wrap: service lands in ms 1030
    button = '0; link_pow = '0; ready = 1'b1;
    step(2);
    reset = 1'b0;
    got.delete();
    step(10290);
    button[5] = 1'b1;
    step(30);
    chk("wrap_count", got.size(), 1);
    chk("wrap_word", word_at(0), 16'h5406);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
